arashi_mem_wr: RTL

Write-back path toward the cache: the opposite direction of the cache-to-thread read buffer.
- Collects per-thread write requests.
- Arbitrates them round-robin, one per cycle.
- Buffers accepted words in a circular FIFO.
- Drains the FIFO to the cache through a registered valid/ack output stage.
- Sits between the thread array and the cache, alongside the read buffer, and uses the same pointer/backlog scheme.

---
 rtl/arashi_mem_pkg.sv | 20 ++
 rtl/arashi_mem_wr_if.sv | 27 ++
 rtl/arashi_wr_arb.sv | 49 ++++
 rtl/arashi_mem_wr.sv | 96 +++++++++
 4 files changed

// File: rtl/arashi_mem_pkg.sv
// Shared definitions for the thread<->cache buffers (read buffer and write-back path).
// Holds default sizes, thread/FIFO derivation helpers and the thread id type.
package arashi_mem_pkg;

   localparam int DEF_DATA_WIDTH       = 32;
   localparam int DEF_THREAD_NUM_WIDTH = 2;
   localparam int DEF_MEM_WIDTH        = 4;

   typedef logic [DEF_THREAD_NUM_WIDTH-1:0] thread_id_t;

   function automatic int thread_num(input int thread_num_width);
      return 1 << thread_num_width;
   endfunction

   // One slot stays unused so that wptr == rptr always means empty.
   function automatic int no_more(input int mem_width);
      return (1 << mem_width) - 1;
   endfunction

endpackage

// File: rtl/arashi_mem_wr_if.sv
// Bundle between the thread array / cache and the write-back buffer.
// slave is the buffer side; master is the thread array plus cache side.
interface arashi_mem_wr_if
   import arashi_mem_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int THREAD_NUM = thread_num(DEF_THREAD_NUM_WIDTH)
);

   logic [THREAD_NUM-1:0]            w_ena;
   logic [DATA_WIDTH*THREAD_NUM-1:0] data_in;
   logic [THREAD_NUM-1:0]            w_ready;
   logic [DATA_WIDTH-1:0]            mem2cache;
   logic                             mem_valid;
   logic                             cache_ack;

   modport master (
      output w_ena, data_in, cache_ack,
      input  w_ready, mem2cache, mem_valid
   );

   modport slave (
      input  w_ena, data_in, cache_ack,
      output w_ready, mem2cache, mem_valid
   );

endinterface

// File: rtl/arashi_wr_arb.sv
// Round-robin arbiter for write requests: picks the first eligible thread after
// the last granted one, at most one grant per cycle.
module arashi_wr_arb
   import arashi_mem_pkg::*;
#(
   parameter  int THREAD_NUM_WIDTH = DEF_THREAD_NUM_WIDTH,
   localparam int THREAD_NUM       = thread_num(THREAD_NUM_WIDTH)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [THREAD_NUM-1:0]       i_eligible,
   input  logic                        i_enable,
   output logic                        o_grant_valid,
   output logic [THREAD_NUM_WIDTH-1:0] o_grant_id
);

   logic [THREAD_NUM_WIDTH-1:0] r_last;
   logic [THREAD_NUM_WIDTH-1:0] w_idx;
   logic [THREAD_NUM_WIDTH-1:0] w_pick;
   logic                        w_found;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_last;
      w_idx   = r_last;
      for (int i = 1; i <= THREAD_NUM; i++) begin
         w_idx = THREAD_NUM_WIDTH'(int'(r_last) + i);
         if (!w_found && i_eligible[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

   assign o_grant_valid = i_enable && w_found;
   assign o_grant_id    = w_pick;

   // Reset to the highest id so thread 0 wins the first contest.
   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= '1;
      end else if (o_grant_valid) begin
         r_last <= w_pick;
      end
   end

endmodule

// File: rtl/arashi_mem_wr.sv
// Write-back buffer: per-thread requests are arbitrated into a circular FIFO
// which drains to the cache through a registered valid/ack stage.
module arashi_mem_wr
   import arashi_mem_pkg::*;
#(
   parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
   parameter int THREAD_NUM_WIDTH = DEF_THREAD_NUM_WIDTH,
   parameter int MEM_WIDTH        = DEF_MEM_WIDTH
) (
   input logic            clk,
   input logic            rst,
   arashi_mem_wr_if.slave bus
);

   localparam int                   THREAD_NUM = thread_num(THREAD_NUM_WIDTH);
   localparam int                   DEPTH      = 1 << MEM_WIDTH;
   localparam logic [MEM_WIDTH-1:0] NO_MORE    = MEM_WIDTH'(no_more(MEM_WIDTH));

   logic [DATA_WIDTH-1:0]       r_mem [DEPTH];
   logic [MEM_WIDTH-1:0]        r_wptr;
   logic [MEM_WIDTH-1:0]        r_rptr;
   logic [MEM_WIDTH-1:0]        w_backlog;
   logic                        w_full;
   logic                        w_empty;
   logic                        w_load;

   logic [THREAD_NUM-1:0]       w_eligible;
   logic                        w_grant_valid;
   logic [THREAD_NUM_WIDTH-1:0] w_grant_id;
   logic [DATA_WIDTH-1:0]       w_grant_data;

   logic [THREAD_NUM-1:0]       r_w_ready;
   logic [DATA_WIDTH-1:0]       r_mem2cache;
   logic                        r_mem_valid;

   // Pointers wrap at 1 << MEM_WIDTH, so modulo subtraction is the fill level.
   assign w_backlog = r_wptr - r_rptr;
   assign w_full    = (w_backlog == NO_MORE);
   assign w_empty   = (w_backlog == '0);

   // A thread whose accept pulse is showing has already been served this round.
   assign w_eligible   = bus.w_ena & ~r_w_ready;
   assign w_grant_data = bus.data_in[int'(w_grant_id) * DATA_WIDTH +: DATA_WIDTH];

   arashi_wr_arb #(
      .THREAD_NUM_WIDTH(THREAD_NUM_WIDTH)
   ) u_arb (
      .clk          (clk),
      .rst          (rst),
      .i_eligible   (w_eligible),
      .i_enable     (!w_full),
      .o_grant_valid(w_grant_valid),
      .o_grant_id   (w_grant_id)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr    <= '0;
         r_w_ready <= '0;
      end else begin
         r_w_ready <= w_grant_valid ? (THREAD_NUM'(1) << w_grant_id) : '0;
         if (w_grant_valid) begin
            r_wptr <= r_wptr + MEM_WIDTH'(1);
         end
      end
   end

   // NOTE: storage has no reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (w_grant_valid) begin
         r_mem[r_wptr] <= w_grant_data;
      end
   end

   // The output register refills whenever it is free or being consumed this cycle.
   assign w_load = (!r_mem_valid || bus.cache_ack) && !w_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rptr      <= '0;
         r_mem_valid <= 1'b0;
         r_mem2cache <= '0;
      end else if (w_load) begin
         r_mem2cache <= r_mem[r_rptr];
         r_rptr      <= r_rptr + MEM_WIDTH'(1);
         r_mem_valid <= 1'b1;
      end else if (r_mem_valid && bus.cache_ack) begin
         r_mem_valid <= 1'b0;
      end
   end

   assign bus.w_ready   = r_w_ready;
   assign bus.mem2cache = r_mem2cache;
   assign bus.mem_valid = r_mem_valid;

endmodule
